// File: rtl/mem_arb2_pkg.sv
// mem_arb2 shared types: arbiter state, default error
// data, counter width and a saturating increment helper.
package mem_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_t;

  localparam logic [31:0] ERR_RDATA_DEF = 32'hDEADBEEF;
  localparam int          CNT_W         = 32;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v,
    input logic             en
  );
    return (en && !(&v)) ? v + CNT_W'(1) : v;
  endfunction

endpackage

// File: rtl/mem_arb2_if.sv
// picorv32-native memory port bundle; master drives the
// request, slave answers with ready/rdata.
interface mem_arb2_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic                valid;
  logic                instr;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                ready;
  logic [DATA_W-1:0]   rdata;

  modport master (
    output valid, instr, addr, wdata, wstrb,
    input  ready, rdata
  );

  modport slave (
    input  valid, instr, addr, wdata, wstrb,
    output ready, rdata
  );

endinterface

// File: rtl/mem_arb2_rr_arb2.sv
// Two-way round-robin grant: the requester that was not
// served last wins a tie. Purely combinational.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      (req == 2'b01): gnt = 2'b01;
      (req == 2'b10): gnt = 2'b10;
      (req == 2'b11): gnt = last ? 2'b01 : 2'b10;
      default:        gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arb2.sv
// Two-core round-robin arbiter for one picorv32 memory port
// with response timeout; MEM_ARB_STATS_EN adds counters.
module mem_arb2
  import mem_arb_pkg::*;
#(
  parameter int               ADDR_W    = 32,
  parameter int               DATA_W    = 32,
  parameter int               PRIO_INIT = 0,
  parameter int               TIMEOUT   = 0,
  parameter logic [DATA_W-1:0] ERR_RDATA =
    DATA_W'(ERR_RDATA_DEF)
) (
  input  logic      clk,
  input  logic      reset,
  mem_arb2_if.slave  m0,
  mem_arb2_if.slave  m1,
  mem_arb2_if.master s,
  output logic      timeout_err
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1,
  output logic [CNT_W-1:0] wait_cnt0,
  output logic [CNT_W-1:0] wait_cnt1
`endif
);

  localparam logic LAST_RST = (PRIO_INIT == 0);
  localparam logic [CNT_W-1:0] TLIM =
    CNT_W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

  arb_state_t        state;
  logic              grant;
  logic              last;
  logic [CNT_W-1:0]  tcnt;
  logic [1:0]        gnt;
  logic              busy;
  logic              expire;
  logic              done;
  logic [DATA_W-1:0] rdat;

  rr_arb2 u_rr (
    .req  ({m1.valid, m0.valid}),
    .last (last),
    .gnt  (gnt)
  );

  assign busy   = (state == ARB_BUSY);
  assign expire = (TIMEOUT > 0) && busy &&
                  !s.ready && (tcnt == TLIM);
  assign done   = busy && (s.ready || expire);
  assign rdat   = expire ? ERR_RDATA : s.rdata;

  assign s.valid = busy;
  assign s.instr = grant ? m1.instr : m0.instr;
  assign s.addr  = grant ? m1.addr  : m0.addr;
  assign s.wdata = grant ? m1.wdata : m0.wdata;
  assign s.wstrb = grant ? m1.wstrb : m0.wstrb;

  assign m0.ready = done && !grant;
  assign m1.ready = done && grant;
  assign m0.rdata = (busy && !grant) ? rdat : '0;
  assign m1.rdata = (busy && grant) ? rdat : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ARB_IDLE;
      grant       <= 1'b0;
      last        <= LAST_RST;
      tcnt        <= '0;
      timeout_err <= 1'b0;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          tcnt <= '0;
          if (|gnt) begin
            grant <= gnt[1];
            state <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (done) begin
            state <= ARB_IDLE;
            last  <= grant;
            tcnt  <= '0;
          end else begin
            tcnt <= tcnt + CNT_W'(1);
          end
          if (expire) timeout_err <= 1'b1;
        end
      endcase
    end
  end

`ifdef MEM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
      wait_cnt0  <= '0;
      wait_cnt1  <= '0;
    end else begin
      grant_cnt0 <= sat_inc(grant_cnt0, m0.ready);
      grant_cnt1 <= sat_inc(grant_cnt1, m1.ready);
      wait_cnt0  <= sat_inc(wait_cnt0,
                            m0.valid && !m0.ready);
      wait_cnt1  <= sat_inc(wait_cnt1,
                            m1.valid && !m1.ready);
    end
  end
`endif

endmodule

// File: tb/tb_mem_arb2.sv
// Bench for mem_arb2: directed core traffic, a latency-
// programmable memory, and a transaction-level model.
module tb_mem_arb2;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic timeout_err;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arb2_if #(.ADDR_W(AW), .DATA_W(DW)) m0 ();
  mem_arb2_if #(.ADDR_W(AW), .DATA_W(DW)) m1 ();
  mem_arb2_if #(.ADDR_W(AW), .DATA_W(DW)) s ();

`ifdef MEM_ARB_STATS_EN
  logic [31:0] gc0, gc1, wc0, wc1;
`endif

  mem_arb2 #(
    .ADDR_W(AW), .DATA_W(DW), .PRIO_INIT(0),
    .TIMEOUT(TO), .ERR_RDATA(ERR)
  ) dut (
    .clk(clk),
    .reset(reset),
    .m0(m0),
    .m1(m1),
    .s(s),
    .timeout_err(timeout_err)
`ifdef MEM_ARB_STATS_EN
    ,
    .grant_cnt0(gc0),
    .grant_cnt1(gc1),
    .wait_cnt0(wc0),
    .wait_cnt1(wc1)
`endif
  );

  function automatic void chk(string nm,
                              logic [63:0] act,
                              logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t",
               nm, act, exp, $time);
    end
  endfunction

  // memory: ready after mem_lat+1 cycles of s_valid; -1 never
  int          mem_lat = 0;
  logic [31:0] mem_data = 32'h0;
  int          s_age = 0;

  initial begin
    s.ready = 1'b0;
    s.rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (s.valid) s_age++;
      else s_age = 0;
      s.ready = s.valid && mem_lat >= 0 &&
                s_age == mem_lat + 1;
      s.rdata = s.ready ? mem_data :
                (32'hBAD00000 | 32'(s_age));
    end
  end

  // transaction-level model: who is being served and for how long
  int owner = -1;
  int prev = 1;
  int age = 0;
  bit err = 1'b0;

  initial forever begin
    @(posedge clk);
    if (reset) begin
      owner = -1;
      prev  = 1;
      age   = 0;
      err   = 1'b0;
    end else if (owner < 0) begin
      age = 0;
      if (m0.valid && m1.valid) owner = 1 - prev;
      else if (m0.valid) owner = 0;
      else if (m1.valid) owner = 1;
    end else if (s.ready || age == TO - 1) begin
      if (!s.ready) err = 1'b1;
      prev  = owner;
      owner = -1;
      age   = 0;
    end else begin
      age++;
    end
  end

`ifdef MEM_ARB_STATS_EN
  int mg0 = 0, mg1 = 0, mw0 = 0, mw1 = 0;
`endif

  initial forever begin
    bit fin;
    logic [31:0] er;
    @(negedge clk);
    fin = owner >= 0 && (s.ready || age == TO - 1);
    er  = s.ready ? s.rdata : ERR;
    chk("s_valid", s.valid, owner >= 0);
    chk("m0_ready", m0.ready, fin && owner == 0);
    chk("m1_ready", m1.ready, fin && owner == 1);
    chk("timeout_err", timeout_err, err);
    if (owner == 0) begin
      chk("s_addr", s.addr, m0.addr);
      chk("s_wdata", s.wdata, m0.wdata);
      chk("s_wstrb", s.wstrb, m0.wstrb);
      chk("s_instr", s.instr, m0.instr);
      chk("m1_rdata", m1.rdata, 0);
      if (fin) chk("m0_rdata", m0.rdata, er);
    end else if (owner == 1) begin
      chk("s_addr", s.addr, m1.addr);
      chk("s_wdata", s.wdata, m1.wdata);
      chk("s_wstrb", s.wstrb, m1.wstrb);
      chk("s_instr", s.instr, m1.instr);
      chk("m0_rdata", m0.rdata, 0);
      if (fin) chk("m1_rdata", m1.rdata, er);
    end else begin
      chk("m0_rdata", m0.rdata, 0);
      chk("m1_rdata", m1.rdata, 0);
    end
`ifdef MEM_ARB_STATS_EN
    chk("grant_cnt0", gc0, mg0);
    chk("grant_cnt1", gc1, mg1);
    chk("wait_cnt0", wc0, mw0);
    chk("wait_cnt1", wc1, mw1);
    if (reset) begin
      mg0 = 0; mg1 = 0; mw0 = 0; mw1 = 0;
    end else begin
      if (fin && owner == 0) mg0++;
      if (fin && owner == 1) mg1++;
      if (m0.valid && !(fin && owner == 0)) mw0++;
      if (m1.valid && !(fin && owner == 1)) mw1++;
    end
`endif
  end

  task automatic set_req(input int c, input logic v,
                         input logic ins,
                         input logic [31:0] a,
                         input logic [31:0] wd,
                         input logic [3:0] ws);
    if (c == 0) begin
      m0.valid = v; m0.instr = ins; m0.addr = a;
      m0.wdata = wd; m0.wstrb = ws;
    end else begin
      m1.valid = v; m1.instr = ins; m1.addr = a;
      m1.wdata = wd; m1.wstrb = ws;
    end
  endtask

  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_wstrb;

  task automatic do_txn(input int c, input logic ins,
                        input logic [31:0] a,
                        input logic [31:0] wd,
                        input logic [3:0] ws,
                        output logic [31:0] rd,
                        output int t0, output int t1);
    bit got = 1'b0;
    @(posedge clk);
    #1;
    set_req(c, 1'b1, ins, a, wd, ws);
    t0 = cyc;
    t1 = -1;
    rd = 32'h0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (c == 0 ? m0.ready : m1.ready) begin
        got = 1'b1;
        t1 = cyc;
        rd = (c == 0) ? m0.rdata : m1.rdata;
        cap_addr = s.addr;
        cap_wdata = s.wdata;
        cap_wstrb = s.wstrb;
      end
    end
    chk("txn_done", got, 1);
    @(posedge clk);
    #1;
    set_req(c, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  logic [31:0] rd0, rd1;
  int a0, b0, a1, b1;

  initial begin
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_s_valid", s.valid, 0);
    chk("rst_m0_ready", m0.ready, 0);
    chk("rst_terr", timeout_err, 0);

    mem_lat = 2;
    mem_data = 32'h12345678;
    do_txn(0, 1'b1, 32'h100, 32'h0, 4'h0, rd0, a0, b0);
    chk("t1_rdata", rd0, 32'h12345678);
    chk("t1_lat", b0 - a0, 3);

    do_reset();
    mem_lat = 0;
    mem_data = 32'h0BADF00D;
    for (int r = 0; r < 2; r++) begin
      fork
        do_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, rd0, a0, b0);
        do_txn(1, 1'b0, 32'h20, 32'h0, 4'h0, rd1, a1, b1);
      join
      chk("t2_m0_first", b0 - a0, 1);
      chk("t2_gap", b1 - b0, 2);
      chk("t2_rdata", rd1, 32'h0BADF00D);
    end

    mem_lat = 1;
    do_txn(1, 1'b0, 32'h200, 32'hA5A5A5A5, 4'b0011,
           rd1, a1, b1);
    chk("t3_addr", cap_addr, 32'h200);
    chk("t3_wdata", cap_wdata, 32'hA5A5A5A5);
    chk("t3_wstrb", cap_wstrb, 4'b0011);
    chk("t3_lat", b1 - a1, 2);

    mem_lat = 7;
    mem_data = 32'hCAFEF00D;
    do_txn(0, 1'b0, 32'h40, 32'h0, 4'h0, rd0, a0, b0);
    chk("t4_tie_rdata", rd0, 32'hCAFEF00D);
    chk("t4_tie_lat", b0 - a0, 8);
    chk("t4_tie_err", timeout_err, 0);

    mem_lat = -1;
    do_txn(0, 1'b0, 32'h44, 32'h0, 4'h0, rd0, a0, b0);
    chk("t4_to_rdata", rd0, 32'hDEADBEEF);
    chk("t4_to_lat", b0 - a0, 8);
    chk("t4_to_err", timeout_err, 1);
    mem_lat = 0;
    do_txn(1, 1'b0, 32'h48, 32'h0, 4'h0, rd1, a1, b1);
    chk("t4_sticky", timeout_err, 1);

    mem_lat = -1;
    @(posedge clk);
    #1 set_req(0, 1'b1, 1'b0, 32'h300, 32'h0, 4'h0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("t5_busy", s.valid, 1);
    @(posedge clk);
    #1 reset = 1'b0;
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    chk("t5_s_valid", s.valid, 0);
    chk("t5_err_clr", timeout_err, 0);
    mem_lat = 0;
    mem_data = 32'h600DCAFE;
    do_txn(1, 1'b0, 32'h304, 32'h0, 4'h0, rd1, a1, b1);
    chk("t5_rdata", rd1, 32'h600DCAFE);
    chk("t5_lat", b1 - a1, 1);

`ifdef MEM_ARB_STATS_EN
    do_reset();
    for (int i = 0; i < 3; i++)
      do_txn(0, 1'b0, 32'h80, 32'h0, 4'h0, rd0, a0, b0);
    for (int i = 0; i < 2; i++)
      do_txn(1, 1'b0, 32'h84, 32'h0, 4'h0, rd1, a1, b1);
    @(negedge clk);
    chk("st_grant0", gc0, 3);
    chk("st_grant1", gc1, 2);
    chk("st_wait0", wc0, 3);
    chk("st_wait1", wc1, 2);
`endif

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
